sprite_anchor_arbiter: RTL and testbench

- Shares the sprite anchor table write port between NUM_REQ independent requesters, e.g. CPU interface and motion engine.
- Accepts (sprite number, anchor) update requests and grants them round-robin.
- Performs each table write only while the VGA column is in horizontal blanking, so anchors never change mid-line.
- Drives the anchor table write port (address, data, active-low write enable) of the sprite renderer.

---
 rtl/sprite_anchor_arbiter.sv | 135 +++++++++++++
 tb/tb_sprite_anchor_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anchor_arbiter.sv
// Round-robin arbiter that shares the sprite anchor table write port between
// NUM_REQ requesters. Each granted update is held until the VGA column reaches
// horizontal blanking, so anchors never change part-way through a line.
module sprite_anchor_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SPRITES = 32,
  parameter int BLANK_START = 640
) (
  input  logic                  clk_75,
  input  logic                  reset,
  input  logic [9:0]            column,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*5-1:0]  sp_num_bus,
  input  logic [NUM_REQ*19-1:0] ancora_bus,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [4:0]            addr_out,
  output logic [18:0]           ancora_out,
  output logic                  ancora_wren_n,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE, ACK} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] grant_sel;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] cand;
  logic             grant_found;
  logic [4:0]       sp_arr  [NUM_REQ];
  logic [18:0]      anc_arr [NUM_REQ];
  logic [4:0]       sp_sel;
  logic [18:0]      anc_sel;
  logic [4:0]       sp_q;
  logic [18:0]      anc_q;
  logic             in_blank;
  logic             sp_bad;

  // One-hot acknowledge for the latched grant index.
  function automatic logic [NUM_REQ-1:0] grant_mask(input logic [IDX_W-1:0] g);
    grant_mask    = '0;
    grant_mask[g] = 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sp_arr[i]  = sp_num_bus[i*5 +: 5];
    assign anc_arr[i] = ancora_bus[i*19 +: 19];
  end

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    grant_sel   = '0;
    grant_found = 1'b0;
    sp_sel      = '0;
    anc_sel     = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
        sp_sel      = sp_arr[cand];
        anc_sel     = anc_arr[cand];
      end
    end
  end

  assign rr_next  = IDX_W'((int'(grant_sel) + 1) % NUM_REQ);
  assign in_blank = (int'(column) >= BLANK_START);
  assign sp_bad   = (int'(sp_q) >= NUM_SPRITES);

  // Capture the winning request's payload; later input changes are ignored.
  always_ff @(posedge clk_75) begin
    if (state == IDLE && grant_found) begin
      sp_q  <= sp_sel;
      anc_q <= anc_sel;
    end
  end

  // Transaction FSM: grant, wait for blanking, single write, acknowledge.
  always_ff @(posedge clk_75 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_q       <= '0;
      ack           <= '0;
      err           <= 1'b0;
      addr_out      <= '0;
      ancora_out    <= '0;
      ancora_wren_n <= 1'b1;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant_q <= grant_sel;
            rr_ptr  <= rr_next;
            busy    <= 1'b1;
            state   <= WAIT_BLANK;
          end
        end
        WAIT_BLANK: begin
          if (sp_bad) begin
            ack   <= grant_mask(grant_q);
            err   <= 1'b1;
            state <= ACK;
          end else if (in_blank) begin
            addr_out      <= sp_q;
            ancora_out    <= anc_q;
            ancora_wren_n <= 1'b0;
            state         <= WRITE;
          end
        end
        WRITE: begin
          ancora_wren_n <= 1'b1;
          ack           <= grant_mask(grant_q);
          err           <= 1'b0;
          state         <= ACK;
        end
        ACK: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_anchor_arbiter.sv
// Scoreboard bench for sprite_anchor_arbiter: expected transactions are queued
// from a round-robin model when requests are raised; a monitor checks writes
// and acknowledges as the DUT produces them.
`timescale 1ns/1ps
module tb_sprite_anchor_arbiter;

  localparam int NR = 4;
  localparam int NS = 20;
  localparam int BS = 640;

  logic            clk = 1'b0;
  logic            rst;
  logic [9:0]      column;
  logic [NR-1:0]   req;
  logic [NR*5-1:0] sp_bus;
  logic [NR*19-1:0] anc_bus;
  logic [NR-1:0]   ack;
  logic            err;
  logic [4:0]      addr_out;
  logic [18:0]     ancora_out;
  logic            wren_n;
  logic            busy;

  logic [4:0]  sp_in  [NR];
  logic [18:0] anc_in [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign sp_bus[g*5 +: 5]    = sp_in[g];
    assign anc_bus[g*19 +: 19] = anc_in[g];
  end

  sprite_anchor_arbiter #(.NUM_REQ(NR), .NUM_SPRITES(NS), .BLANK_START(BS)) dut (
    .clk_75(clk), .reset(rst), .column(column), .req(req),
    .sp_num_bus(sp_bus), .ancora_bus(anc_bus), .ack(ack), .err(err),
    .addr_out(addr_out), .ancora_out(ancora_out), .ancora_wren_n(wren_n), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [4:0]  sp;
    logic [18:0] anc;
    bit          rej;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          model_rr = 0;
  int          scen_id = 0;
  bit          exact_gap = 0;
  bit          col_run = 0;
  logic [9:0]  col_fixed = 10'd700;
  logic [4:0]  sp_tab  [NR][4];
  logic [18:0] anc_tab [NR][4];
  int          cnt [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Column source: either parked at col_fixed or counting 0..799.
  initial begin
    column = 10'd0;
    forever begin
      @(posedge clk);
      #1;
      if (col_run) column = (column >= 10'd799) ? 10'd0 : column + 10'd1;
      else         column = col_fixed;
    end
  end

  // Monitor: every write and acknowledge is compared with the queue front.
  bit         wr_prev = 0;
  bit         ack_prev = 0;
  logic [9:0] prev_col = '0;
  int         cyc = 0;
  int         last_wr = -100;
  int         gap_scen = -1;
  txn_t       t;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (!wren_n) begin
        check("wren_single_cycle", wr_prev, 0);
        check("write_in_blank", prev_col >= 10'(BS), 1);
        check("busy_during_write", busy, 1);
        check("write_spacing", (cyc - last_wr) >= 4, 1);
        if (exact_gap && gap_scen == scen_id) check("write_gap", cyc - last_wr, 4);
        gap_scen = scen_id;
        last_wr  = cyc;
        if (exp_q.size() == 0) check("unexpected_write", !wren_n, 0);
        else if (exp_q[0].rej) check("no_write_on_reject", !wren_n, 0);
        else begin
          check("wr_addr", addr_out, exp_q[0].sp);
          check("wr_data", ancora_out, exp_q[0].anc);
        end
      end
      if (ack != '0) begin
        check("busy_during_ack", busy, 1);
        if (exp_q.size() == 0) check("unexpected_ack", ack, 0);
        else begin
          t = exp_q.pop_front();
          check("ack_grant", ack, 32'd1 << t.idx);
          check("err_flag", err, t.rej);
          check("write_before_ack", wr_prev, !t.rej);
        end
      end else if (err) begin
        check("err_without_ack", err, 0);
      end
      if (ack_prev) check("busy_after_ack", busy, 0);
    end
    wr_prev  = !wren_n;
    ack_prev = (ack != '0);
    prev_col = column;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
  endtask

  // Queue the round-robin order implied by cnt[], then act as the requesters.
  task automatic run_batch(input bit lat_check, input bit abort_wr);
    int  left [NR];
    int  k [NR];
    int  total;
    int  rr;
    int  budget;
    bit  aborted;
    bit  lat_wr_done;
    bit  lat_ack_done;
    total = 0;
    for (int i = 0; i < NR; i++) begin
      left[i] = cnt[i];
      k[i]    = 0;
      total  += cnt[i];
    end
    rr = model_rr;
    for (int n = 0; n < total; n++) begin
      for (int s = 0; s < NR; s++) begin
        int c;
        txn_t e;
        c = (rr + s) % NR;
        if (left[c] > 0) begin
          e.idx = c;
          e.sp  = sp_tab[c][cnt[c] - left[c]];
          e.anc = anc_tab[c][cnt[c] - left[c]];
          e.rej = (int'(e.sp) >= NS);
          exp_q.push_back(e);
          left[c]--;
          rr = (c + 1) % NR;
          break;
        end
      end
    end
    model_rr = rr;
    scen_id++;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (cnt[i] > 0) begin
        sp_in[i]  = sp_tab[i][0];
        anc_in[i] = anc_tab[i][0];
        req[i]    = 1'b1;
      end
    end
    budget = 0;
    aborted = 0;
    lat_wr_done = 0;
    lat_ack_done = 0;
    while (exp_q.size() > 0 && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (lat_check && !wren_n && !lat_wr_done) begin
        check("wren_latency", budget, 2);
        lat_wr_done = 1;
      end
      if (lat_check && ack != '0 && !lat_ack_done) begin
        check("ack_latency", budget, 3);
        lat_ack_done = 1;
      end
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && req[i]) begin
          k[i]++;
          if (k[i] >= cnt[i]) req[i] = 1'b0;
          else begin
            sp_in[i]  = sp_tab[i][k[i]];
            anc_in[i] = anc_tab[i][k[i]];
          end
        end
      end
      if (abort_wr && !aborted && !wren_n) begin
        aborted = 1;
        #2 rst = 1'b1;
        #1;
        check("abort_wren_n", wren_n, 1);
        check("abort_busy", busy, 0);
        check("abort_ack", ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    if (abort_wr) check("abort_happened", aborted, 1);
    if (exp_q.size() > 0) begin
      check("batch_timeout", exp_q.size(), 0);
      exp_q.delete();
      req = '0;
      do_reset();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_batch();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      for (int j = 0; j < 4; j++) begin
        sp_tab[i][j]  = 5'($urandom_range(0, 31));
        anc_tab[i][j] = 19'($urandom);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NR; i++) begin
      sp_in[i]  = '0;
      anc_in[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_addr", addr_out, 0);
    check("rst_data", ancora_out, 0);
    check("rst_wren_n", wren_n, 1);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Basic write with column already in blank.
    clear_batch();
    cnt[0] = 1; sp_tab[0][0] = 5'd3; anc_tab[0][0] = 19'h1A2B3;
    run_batch(1, 0);

    // Write deferred until the column reaches blanking.
    col_fixed = 10'd600;
    repeat (2) @(negedge clk);
    col_run = 1;
    clear_batch();
    cnt[1] = 1; sp_tab[1][0] = 5'd7;
    run_batch(0, 0);
    col_run = 0;
    col_fixed = 10'd700;
    repeat (2) @(negedge clk);

    // All four together from a fresh pointer: writes back to back.
    do_reset();
    exact_gap = 1;
    clear_batch();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 1;
      sp_tab[i][0] = 5'($urandom_range(0, NS - 1));
    end
    run_batch(0, 0);
    exact_gap = 0;

    // Out-of-range sprite number is rejected without a write.
    clear_batch();
    cnt[2] = 1; sp_tab[2][0] = 5'd31;
    run_batch(0, 0);

    // Reset during the write cycle; the request is served again afterwards.
    clear_batch();
    cnt[1] = 1; sp_tab[1][0] = 5'd9;
    run_batch(0, 1);

    // Requester 0 keeps requesting while requester 3 competes.
    clear_batch();
    cnt[0] = 3; cnt[3] = 2;
    for (int j = 0; j < 4; j++) begin
      sp_tab[0][j] = 5'($urandom_range(0, NS - 1));
      sp_tab[3][j] = 5'($urandom_range(0, NS - 1));
    end
    run_batch(0, 0);

    // Randomized batches with fixed or running column.
    for (int r = 0; r < 14; r++) begin
      clear_batch();
      for (int i = 0; i < NR; i++) cnt[i] = $urandom_range(0, 3);
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, NR - 1)] = 1;
      if ($urandom_range(0, 1) == 1) begin
        col_fixed = 10'($urandom_range(0, 799));
        repeat (2) @(negedge clk);
        col_run = 1;
      end else begin
        col_fixed = 10'($urandom_range(BS, 799));
        repeat (2) @(negedge clk);
      end
      run_batch(0, 0);
      col_run = 0;
      col_fixed = 10'd700;
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
